// File: rtl/mem_responder.sv
// Single-port word memory that answers one CPU request at a time after a fixed
// latency, flagging misaligned, out-of-range or conflicting requests as errors.
module mem_responder #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy,
   output logic [15:0] acc_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           accept_c;
   logic           enter_resp_c;
   logic           illegal_c;
   logic [15:0]    acc_count_nxt;

   logic           lat_rd;
   logic           lat_wr;
   logic           lat_ill;
   logic [AW-1:0]  lat_idx;
   logic [31:0]    lat_wdata;

   logic [31:0]    mem [DEPTH];

   // Legality of the request currently on the inputs
   always_comb begin
      illegal_c = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0) || (req_read && req_write);
   end

   // Next-state logic and latency countdown
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      accept_c     = 1'b0;
      enter_resp_c = 1'b0;
      case (state)
         IDLE: begin
            if (req_read || req_write) begin
               accept_c  = 1'b1;
               state_nxt = WAIT;
               cnt_nxt   = CW'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               state_nxt    = RESP;
               enter_resp_c = 1'b1;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Saturating count of clean completions; registered every cycle
   always_comb begin
      acc_count_nxt = acc_count;
      if (enter_resp_c && !lat_ill && (acc_count != 16'hFFFF)) begin
         acc_count_nxt = acc_count + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         ready     <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         acc_count <= '0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_ill   <= 1'b0;
         lat_idx   <= '0;
         lat_wdata <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         busy      <= (state_nxt != IDLE);
         ready     <= enter_resp_c;
         err       <= enter_resp_c && lat_ill;
         acc_count <= acc_count_nxt;
         if (accept_c) begin
            lat_rd    <= req_read;
            lat_wr    <= req_write;
            lat_ill   <= illegal_c;
            lat_idx   <= addr[AW+1:2];
            lat_wdata <= wdata;
         end
         if (enter_resp_c) begin
            if (lat_ill) begin
               rdata <= '0;
            end else if (lat_rd) begin
               rdata <= mem[lat_idx];
            end
         end
      end
   end

   // Backing store is never reset; the write lands on entry to RESP
   always_ff @(posedge clk) begin
      if (enter_resp_c && lat_wr && !lat_ill) begin
         mem[lat_idx] <= lat_wdata;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder against a word-array model;
// a second instance runs at LATENCY=1 for the saturation scenario.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        r1, w1, r2, w2;
   logic [31:0] a1, d1, a2, d2;
   logic [31:0] rdata1, rdata2;
   logic        ready1, ready2, err1, err2, busy1, busy2;
   logic [15:0] acc1, acc2;

   int errors = 0;
   int checks = 0;

   // Reference model for the LATENCY=2 instance
   logic [31:0] m_mem   [256];
   bit          m_known [256];
   logic [31:0] m_rdata;
   bit          m_rknown;
   logic [15:0] m_acc;

   mem_responder #(.LATENCY(2), .DEPTH(256)) dut1 (
      .clk(clk), .reset(reset), .req_read(r1), .req_write(w1), .addr(a1), .wdata(d1),
      .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1), .acc_count(acc1));

   mem_responder #(.LATENCY(1), .DEPTH(256)) dut2 (
      .clk(clk), .reset(reset), .req_read(r2), .req_write(w2), .addr(a2), .wdata(d2),
      .rdata(rdata2), .ready(ready2), .err(err2), .busy(busy2), .acc_count(acc2));

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_rdata  = '0;
      m_rknown = 1'b1;
      m_acc    = '0;
   endfunction

   // Applies one transaction to the model; returns the expected err flag
   function automatic bit model_step(input bit rd, input bit wr, input logic [31:0] a,
                                     input logic [31:0] d);
      bit ill;
      int idx;
      ill = (a % 4 != 0) || (a >= 32'd1024) || (rd && wr);
      idx = int'(a / 4);
      if (ill) begin
         m_rdata  = '0;
         m_rknown = 1'b1;
         return 1'b1;
      end
      if (wr) begin
         m_mem[idx]   = d;
         m_known[idx] = 1'b1;
      end
      if (rd) begin
         m_rdata  = m_mem[idx];
         m_rknown = m_known[idx];
      end
      if (m_acc != 16'hFFFF) m_acc = m_acc + 16'd1;
      return 1'b0;
   endfunction

   // Issues one request and reports what the DUT did; lat=-1 on timeout
   task automatic run_access(input bit sel, input bit rd, input bit wr,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic e, output logic [31:0] rdo,
                             output logic [15:0] acco, output logic rdy_after);
      int k;
      lat = -1; e = 1'bx; rdo = 'x; acco = 'x; rdy_after = 1'bx;
      @(negedge clk);
      for (int i = 0; i < 40 && (sel ? busy2 : busy1); i++) @(negedge clk);
      if (sel) begin r2 = rd; w2 = wr; a2 = a; d2 = d; end
      else     begin r1 = rd; w1 = wr; a1 = a; d1 = d; end
      @(negedge clk);
      if (sel) begin r2 = 0; w2 = 0; end else begin r1 = 0; w1 = 0; end
      k = 1;
      while (k <= 40) begin
         if (sel ? ready2 : ready1) begin
            lat  = k - 1;
            e    = sel ? err2 : err1;
            rdo  = sel ? rdata2 : rdata1;
            acco = sel ? acc2 : acc1;
            @(negedge clk);
            rdy_after = sel ? ready2 : ready1;
            break;
         end
         k++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12 reset = 1'b0;
      #1;
      checks++;
      if ({ready1, err1, busy1, rdata1, acc1} !== 51'd0) begin
         errors++;
         $display("FAIL reset_dut1: got rdy=%b err=%b busy=%b rdata=%h acc=%h want all 0",
                  ready1, err1, busy1, rdata1, acc1);
      end
      checks++;
      if ({ready2, err2, busy2, rdata2, acc2} !== 51'd0) begin
         errors++;
         $display("FAIL reset_dut2: got rdy=%b err=%b busy=%b rdata=%h acc=%h want all 0",
                  ready2, err2, busy2, rdata2, acc2);
      end
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_write_read();
      int lat; logic e, ra; logic [31:0] rd; logic [15:0] ac;
      bit ee;
      ee = model_step(0, 1, 32'h10, 32'hDEADBEEF);
      run_access(0, 0, 1, 32'h10, 32'hDEADBEEF, lat, e, rd, ac, ra);
      checks++;
      if (lat !== 2 || e !== ee) begin
         errors++; $display("FAIL wr_latency: got lat=%0d err=%b want lat=2 err=%b", lat, e, ee);
      end
      ee = model_step(1, 0, 32'h10, 32'h0);
      run_access(0, 1, 0, 32'h10, 32'h0, lat, e, rd, ac, ra);
      checks++;
      if (lat !== 2 || e !== 1'b0 || rd !== 32'hDEADBEEF || ac !== 16'd2 || ra !== 1'b0) begin
         errors++;
         $display("FAIL rd_after_wr: got lat=%0d err=%b rdata=%h acc=%0d rdy_next=%b want 2 0 deadbeef 2 0",
                  lat, e, rd, ac, ra);
      end
   endtask

   task automatic test_illegal();
      int lat; logic e, ra; logic [31:0] rd; logic [15:0] ac;
      bit ee;
      logic [31:0] a_tab [3] = '{32'h13, 32'h400, 32'h0};
      bit          w_tab [3] = '{1'b0, 1'b1, 1'b1};
      bit          r_tab [3] = '{1'b1, 1'b0, 1'b1};
      ee = model_step(0, 1, 32'h0, 32'h0BADF00D);
      run_access(0, 0, 1, 32'h0, 32'h0BADF00D, lat, e, rd, ac, ra);
      for (int i = 0; i < 3; i++) begin
         ee = model_step(r_tab[i], w_tab[i], a_tab[i], 32'hFFFF0000);
         run_access(0, r_tab[i], w_tab[i], a_tab[i], 32'hFFFF0000, lat, e, rd, ac, ra);
         checks++;
         if (lat !== 2 || e !== 1'b1 || ee !== 1'b1 || rd !== 32'h0 || ac !== m_acc) begin
            errors++;
            $display("FAIL illegal_%0d: got lat=%0d err=%b rdata=%h acc=%0d want 2 1 0 %0d",
                     i, lat, e, rd, ac, m_acc);
         end
      end
      ee = model_step(1, 0, 32'h0, 32'h0);
      run_access(0, 1, 0, 32'h0, 32'h0, lat, e, rd, ac, ra);
      checks++;
      if (e !== 1'b0 || rd !== 32'h0BADF00D || ac !== m_acc) begin
         errors++;
         $display("FAIL word0_intact: got err=%b rdata=%h acc=%0d want 0 0badf00d %0d", e, rd, ac, m_acc);
      end
   endtask

   task automatic test_busy_ignore();
      int lat, nrdy; logic e, ra; logic [31:0] rd; logic [15:0] ac;
      bit ee;
      ee = model_step(0, 1, 32'h20, 32'h600DCAFE);
      run_access(0, 0, 1, 32'h20, 32'h600DCAFE, lat, e, rd, ac, ra);
      ee = model_step(0, 1, 32'h24, 32'h11112222);
      @(negedge clk);
      w1 = 1; a1 = 32'h24; d1 = 32'h11112222;
      @(negedge clk);
      checks++;
      if (busy1 !== 1'b1) begin
         errors++; $display("FAIL busy_high: got %b want 1", busy1);
      end
      a1 = 32'h20; d1 = 32'h12345678;
      nrdy = 0;
      for (int i = 0; i < 8; i++) begin
         if (ready1) nrdy++;
         if (i == 2) w1 = 0;
         @(negedge clk);
      end
      checks++;
      if (nrdy !== 1) begin
         errors++; $display("FAIL busy_one_ready: got %0d ready pulses want 1", nrdy);
      end
      ee = model_step(1, 0, 32'h20, 32'h0);
      run_access(0, 1, 0, 32'h20, 32'h0, lat, e, rd, ac, ra);
      checks++;
      if (rd !== 32'h600DCAFE || e !== 1'b0 || ac !== m_acc) begin
         errors++;
         $display("FAIL busy_no_write: got rdata=%h err=%b acc=%0d want 600dcafe 0 %0d", rd, e, ac, m_acc);
      end
   endtask

   task automatic test_reset_mid();
      int lat, nrdy; logic e, ra; logic [31:0] rd; logic [15:0] ac;
      bit ee;
      ee = model_step(0, 1, 32'h8, 32'h5A5A0001);
      run_access(0, 0, 1, 32'h8, 32'h5A5A0001, lat, e, rd, ac, ra);
      @(negedge clk);
      w1 = 1; a1 = 32'h8; d1 = 32'hA5A5A5A5;
      @(negedge clk);
      w1 = 0;
      reset = 1'b0;
      #1;
      checks++;
      if ({ready1, err1, busy1, rdata1, acc1} !== 51'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got rdy=%b err=%b busy=%b rdata=%h acc=%h want all 0",
                  ready1, err1, busy1, rdata1, acc1);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      nrdy = 0;
      for (int i = 0; i < 8; i++) begin
         if (ready1) nrdy++;
         @(negedge clk);
      end
      checks++;
      if (nrdy !== 0) begin
         errors++; $display("FAIL reset_mid_no_ready: got %0d ready pulses want 0", nrdy);
      end
      ee = model_step(1, 0, 32'h8, 32'h0);
      run_access(0, 1, 0, 32'h8, 32'h0, lat, e, rd, ac, ra);
      checks++;
      if (rd !== 32'h5A5A0001 || e !== 1'b0 || ac !== 16'd1) begin
         errors++;
         $display("FAIL reset_mid_no_write: got rdata=%h err=%b acc=%0d want 5a5a0001 0 1", rd, e, ac);
      end
   endtask

   task automatic test_random();
      int lat; logic e, ra; logic [31:0] rd; logic [15:0] ac;
      bit ee, rq, wq;
      logic [31:0] a, d;
      int kind;
      for (int n = 0; n < 60; n++) begin
         a = 32'($urandom_range(0, 15)) * 4;
         kind = int'($urandom_range(0, 9));
         if (kind == 0) a = a | 32'($urandom_range(1, 3));
         if (kind == 1) a = a + 32'h400 + (32'($urandom_range(0, 3)) << 20);
         rq = ($urandom_range(0, 1) == 1);
         wq = !rq;
         if (kind == 2) begin rq = 1; wq = 1; end
         d = $urandom;
         ee = model_step(rq, wq, a, d);
         run_access(0, rq, wq, a, d, lat, e, rd, ac, ra);
         checks++;
         if (lat !== 2 || e !== ee || ac !== m_acc || ra !== 1'b0
             || (m_rknown && rd !== m_rdata)) begin
            errors++;
            $display("FAIL random_%0d: a=%h rd=%b wr=%b got lat=%0d err=%b rdata=%h acc=%0d rdy_next=%b want 2 %b %h %0d 0",
                     n, a, rq, wq, lat, e, rd, ac, ra, ee, m_rdata, m_acc);
         end
      end
   endtask

   task automatic test_saturation_lat1();
      int lat; logic e, ra; logic [31:0] rd; logic [15:0] ac;
      @(negedge clk);
      force dut2.acc_count = 16'hFFFE;
      repeat (2) @(negedge clk);
      release dut2.acc_count;
      #1;
      checks++;
      if (acc2 !== 16'hFFFE) begin
         errors++; $display("FAIL sat_preset: got acc=%h want fffe", acc2);
      end
      run_access(1, 0, 1, 32'h40, 32'hC0FFEE11, lat, e, rd, ac, ra);
      checks++;
      if (lat !== 1 || e !== 1'b0 || ac !== 16'hFFFF || ra !== 1'b0) begin
         errors++;
         $display("FAIL sat_first: got lat=%0d err=%b acc=%h rdy_next=%b want 1 0 ffff 0", lat, e, ac, ra);
      end
      run_access(1, 1, 0, 32'h40, 32'h0, lat, e, rd, ac, ra);
      checks++;
      if (lat !== 1 || e !== 1'b0 || ac !== 16'hFFFF || rd !== 32'hC0FFEE11) begin
         errors++;
         $display("FAIL sat_second: got lat=%0d err=%b acc=%h rdata=%h want 1 0 ffff c0ffee11",
                  lat, e, ac, rd);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (acc2 !== 16'hFFFF) begin
         errors++; $display("FAIL sat_hold: got acc=%h want ffff", acc2);
      end
   endtask

   initial begin
      r1 = 0; w1 = 0; a1 = '0; d1 = '0;
      r2 = 0; w2 = 0; a2 = '0; d2 = '0;
      for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
      model_reset();
      test_reset();
      test_write_read();
      test_illegal();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      test_saturation_lat1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
